// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package inst_fetch_pkg;

  localparam int unsigned XLEN = 32;

  // addi x0,x0,0
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH_IDLE  = 2'd0,
    FETCH_REQ   = 2'd1,
    FETCH_WAIT  = 2'd2,
    FETCH_VALID = 2'd3
  } fetch_state_e;

  // Request payload presented to instruction memory
  typedef struct packed {
    logic            req;
    logic [XLEN-1:0] addr;
  } imem_req_t;

endpackage

// File: rtl/inst_fetch_pc_next.sv
// Next-PC selection: sequential PC+4 or word-aligned redirect target.
module inst_fetch_pc_next
  import inst_fetch_pkg::*;
(
  input  logic [31:0] pc_q,
  input  logic        pc_sel,
  input  logic [31:0] alu_target,
  output logic [31:0] pc_next,
  output logic [31:0] pc_plus4,
  output logic        misalign_err_d
);

  // Modulo-2^32 increment; wraps with no flag
  assign pc_plus4 = pc_q + 32'(4);

  // Redirect target always has its low two bits dropped
  assign pc_next = pc_sel ? {alu_target[XLEN-1:2], 2'b00} : pc_plus4;

  // Redirect to a target that was not word aligned
  assign misalign_err_d = pc_sel & (|alu_target[1:0]);

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: holds the PC, issues one imem request at a time and
// presents the returned word to the decoder.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        PCSel,
  input  logic [31:0] alu_target,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Inst,
  output logic [31:0] PC,
  output logic [31:0] PC_plus4,
  output logic        inst_valid,
  output logic        misalign_err
);

  localparam logic [XLEN-1:0] RESET_PC_ALIGNED = {RESET_PC[XLEN-1:2], 2'b00};

  fetch_state_e    state_q;
  fetch_state_e    state_d;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] inst_q;
  logic            inst_valid_q;
  logic            misalign_q;
  logic [XLEN-1:0] pc_next;
  logic [XLEN-1:0] pc_plus4;
  logic            misalign_err_d;
  imem_req_t       imem_c;

  inst_fetch_pc_next u_pc_next (
    .pc_q           (pc_q),
    .pc_sel         (PCSel),
    .alu_target     (alu_target),
    .pc_next        (pc_next),
    .pc_plus4       (pc_plus4),
    .misalign_err_d (misalign_err_d)
  );

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= FETCH_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH_IDLE:  state_d = FETCH_REQ;
      FETCH_REQ:   if (imem_ready)  state_d = FETCH_WAIT;
      FETCH_WAIT:  if (imem_rvalid) state_d = FETCH_VALID;
      FETCH_VALID: if (!stall)      state_d = FETCH_REQ;
      default:     state_d = FETCH_IDLE;
    endcase
  end

  // Memory request decoded from state and PC only
  always_comb begin
    imem_c      = '0;
    imem_c.addr = pc_q;
    if (state_q == FETCH_REQ) begin
      imem_c.req = 1'b1;
    end
  end

  // PC, instruction capture and misalignment pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q         <= RESET_PC_ALIGNED;
      inst_q       <= NOP_INST;
      inst_valid_q <= 1'b0;
      misalign_q   <= 1'b0;
    end else begin
      misalign_q <= 1'b0;
      case (state_q)
        FETCH_WAIT: begin
          // Responses in any other state are stale and dropped
          if (imem_rvalid) begin
            inst_q       <= imem_rdata;
            inst_valid_q <= 1'b1;
          end
        end
        FETCH_VALID: begin
          if (!stall) begin
            pc_q         <= pc_next;
            inst_valid_q <= 1'b0;
            misalign_q   <= misalign_err_d;
          end
        end
        default: ;
      endcase
    end
  end

  assign imem_req     = imem_c.req;
  assign imem_addr    = imem_c.addr;
  assign Inst         = inst_valid_q ? inst_q : NOP_INST;
  assign PC           = pc_q;
  assign PC_plus4     = pc_plus4;
  assign inst_valid   = inst_valid_q;
  assign misalign_err = misalign_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with RESET_PC = 0x1000.
module tb_inst_fetch;

  logic        clk;
  logic        reset_n;
  logic        PCSel;
  logic [31:0] alu_target;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] Inst;
  logic [31:0] PC;
  logic [31:0] PC_plus4;
  logic        inst_valid;
  logic        misalign_err;

  int errors = 0;
  int checks = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  inst_fetch #(.RESET_PC(32'h0000_1000)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .PCSel        (PCSel),
    .alu_target   (alu_target),
    .stall        (stall),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .Inst         (Inst),
    .PC           (PC),
    .PC_plus4     (PC_plus4),
    .inst_valid   (inst_valid),
    .misalign_err (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; outputs are sampled and inputs driven at negedge
  task automatic step();
    @(negedge clk);
  endtask

  // From a negedge in FETCH: accept, return data next cycle, land in VALID
  task automatic do_fetch(input logic [31:0] data);
    imem_ready = 1'b1;
    step();
    imem_ready  = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    step();
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    step();
    step();
    checks++; if (Inst !== NOP) begin errors++; $display("FAIL reset_inst got=%h exp=%h", Inst, NOP); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", inst_valid); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", imem_req); end
    checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL reset_misalign got=%b exp=0", misalign_err); end
    checks++; if (PC !== 32'h0000_1000) begin errors++; $display("FAIL reset_pc got=%h exp=00001000", PC); end
    reset_n = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL idle_req got=%b exp=0", imem_req); end
    step();
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL first_req got=%b exp=1", imem_req); end
    checks++; if (imem_addr !== 32'h0000_1000) begin errors++; $display("FAIL first_addr got=%h exp=00001000", imem_addr); end
  endtask

  task automatic test_sequential();
    logic [31:0] data [3];
    logic [31:0] exp_pc;
    data[0] = 32'h0000_0033;
    data[1] = 32'h0040_0093;
    data[2] = 32'h0080_0113;
    for (int i = 0; i < 3; i++) begin
      exp_pc = 32'h0000_1000 + 32'(4 * i);
      checks++; if (imem_addr !== exp_pc || imem_req !== 1'b1) begin errors++; $display("FAIL seq_req[%0d] got=%b/%h exp=1/%h", i, imem_req, imem_addr, exp_pc); end
      do_fetch(data[i]);
      checks++; if (Inst !== data[i]) begin errors++; $display("FAIL seq_inst[%0d] got=%h exp=%h", i, Inst, data[i]); end
      checks++; if (PC !== exp_pc) begin errors++; $display("FAIL seq_pc[%0d] got=%h exp=%h", i, PC, exp_pc); end
      checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL seq_valid[%0d] got=%b exp=1", i, inst_valid); end
      checks++; if (PC_plus4 !== exp_pc + 32'd4) begin errors++; $display("FAIL seq_pc4[%0d] got=%h exp=%h", i, PC_plus4, exp_pc + 32'd4); end
      step();
      checks++; if (inst_valid !== 1'b0 || Inst !== NOP) begin errors++; $display("FAIL seq_nop[%0d] got=%b/%h exp=0/%h", i, inst_valid, Inst, NOP); end
    end
  endtask

  task automatic test_branch();
    checks++; if (imem_addr !== 32'h0000_100C) begin errors++; $display("FAIL br_pre_addr got=%h exp=0000100c", imem_addr); end
    do_fetch(32'h0000_0063);
    PCSel      = 1'b1;
    alu_target = 32'h0000_2000;
    step();
    PCSel      = 1'b0;
    alu_target = 32'h0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0000_2000) begin errors++; $display("FAIL br_addr got=%b/%h exp=1/00002000", imem_req, imem_addr); end
    checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL br_misalign got=%b exp=0", misalign_err); end
  endtask

  task automatic test_misalign();
    do_fetch(32'h0000_006F);
    PCSel      = 1'b1;
    alu_target = 32'h0000_2002;
    step();
    PCSel      = 1'b0;
    alu_target = 32'h0;
    checks++; if (misalign_err !== 1'b1) begin errors++; $display("FAIL mis_pulse got=%b exp=1", misalign_err); end
    checks++; if (imem_addr !== 32'h0000_2000) begin errors++; $display("FAIL mis_addr got=%h exp=00002000", imem_addr); end
    step();
    checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL mis_one_cycle got=%b exp=0", misalign_err); end
  endtask

  task automatic test_stall();
    do_fetch(32'h00C0_0193);
    stall      = 1'b1;
    PCSel      = 1'b1;
    alu_target = 32'h0000_3000;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (Inst !== 32'h00C0_0193 || PC !== 32'h0000_2000) begin errors++; $display("FAIL stall_hold[%0d] got=%h/%h exp=00c00193/00002000", i, Inst, PC); end
      checks++; if (imem_req !== 1'b0 || inst_valid !== 1'b1) begin errors++; $display("FAIL stall_req[%0d] got=%b/%b exp=0/1", i, imem_req, inst_valid); end
    end
    stall      = 1'b0;
    PCSel      = 1'b0;
    alu_target = 32'h0;
    step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0000_2004) begin errors++; $display("FAIL stall_release got=%b/%h exp=1/00002004", imem_req, imem_addr); end
  endtask

  task automatic test_slow_mem();
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    for (int i = 0; i < 4; i++) begin
      step();
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0000_2004) begin errors++; $display("FAIL slow_hold[%0d] got=%b/%h exp=1/00002004", i, imem_req, imem_addr); end
      checks++; if (inst_valid !== 1'b0 || Inst !== NOP) begin errors++; $display("FAIL slow_spurious[%0d] got=%b/%h exp=0/%h", i, inst_valid, Inst, NOP); end
    end
    do_fetch(32'h0100_0213);
    checks++; if (Inst !== 32'h0100_0213 || PC !== 32'h0000_2004) begin errors++; $display("FAIL slow_inst got=%h/%h exp=01000213/00002004", Inst, PC); end
    step();
    checks++; if (imem_addr !== 32'h0000_2008) begin errors++; $display("FAIL slow_next got=%h exp=00002008", imem_addr); end
  endtask

  task automatic test_reset_mid_wait();
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    reset_n    = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0 || PC !== 32'h0000_1000 || inst_valid !== 1'b0) begin errors++; $display("FAIL rst_wait got=%b/%h/%b exp=0/00001000/0", imem_req, PC, inst_valid); end
    step();
    reset_n     = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0BAD_0BAD;
    step();
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    checks++; if (inst_valid !== 1'b0 || Inst !== NOP) begin errors++; $display("FAIL rst_no_capture got=%b/%h exp=0/%h", inst_valid, Inst, NOP); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0000_1000) begin errors++; $display("FAIL rst_refetch got=%b/%h exp=1/00001000", imem_req, imem_addr); end
  endtask

  task automatic test_wrap();
    do_fetch(32'h0000_0013);
    PCSel      = 1'b1;
    alu_target = 32'hFFFF_FFFC;
    step();
    PCSel      = 1'b0;
    alu_target = 32'h0;
    checks++; if (imem_addr !== 32'hFFFF_FFFC || misalign_err !== 1'b0) begin errors++; $display("FAIL wrap_target got=%h/%b exp=fffffffc/0", imem_addr, misalign_err); end
    do_fetch(32'h0000_00B3);
    checks++; if (PC !== 32'hFFFF_FFFC || PC_plus4 !== 32'h0000_0000) begin errors++; $display("FAIL wrap_pc4 got=%h/%h exp=fffffffc/00000000", PC, PC_plus4); end
    step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0000) begin errors++; $display("FAIL wrap_addr got=%b/%h exp=1/00000000", imem_req, imem_addr); end
  endtask

  initial begin
    reset_n     = 1'b0;
    PCSel       = 1'b0;
    alu_target  = 32'h0;
    stall       = 1'b0;
    imem_ready  = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    test_reset();
    test_sequential();
    test_branch();
    test_misalign();
    test_stall();
    test_slow_mem();
    test_reset_mid_wait();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch stage of the single-cycle RISC-V core, directly upstream of `control_logic`. It holds the program counter and issues one word-aligned request at a time to the instruction memory. It presents the returned word as `Inst` to the decoder. Once the decoder's `PCSel` is known and the back end is not stalled, it advances to `PC+4` or to the ALU-computed branch/jump target.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, address of the first fetch after reset. Bits [1:0] must be 0.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `PCSel`  in  1  from `control_logic`: 0 = PC+4, 1 = `alu_target`
- `alu_target`  in  32  branch/jump target from the ALU
- `stall`  in  1  back end not ready; hold the current instruction
- `imem_req`  out  1  request valid to instruction memory
- `imem_addr`  out  32  word-aligned fetch address
- `imem_ready`  in  1  memory accepts the request this cycle
- `imem_rvalid`  in  1  read data valid
- `imem_rdata`  in  32  read data
- `Inst`  out  32  instruction to `control_logic`; NOP when not valid
- `PC`  out  32  address of `Inst`
- `PC_plus4`  out  32  PC+4, for JAL link writeback
- `inst_valid`  out  1  `Inst`/`PC` hold a fetched instruction
- `misalign_err`  out  1  one-cycle pulse: redirect target had bits [1:0] ≠ 0

## Operation
- FSM states: IDLE, FETCH, WAIT, VALID. Reset state is IDLE.
- IDLE → FETCH unconditionally on the next clock.
- FETCH:
  - `imem_req`=1 and `imem_addr`=`pc_q`.
  - On `imem_ready`=1, go to WAIT. Otherwise stay, holding `imem_addr` stable.
- WAIT:
  - `imem_req`=0.
  - On `imem_rvalid`=1, load `inst_q` with `imem_rdata`, set `inst_valid`=1, and go to VALID.
- VALID:
  - `Inst`=`inst_q` and `PC`=`pc_q`.
  - If `stall`=0: `pc_q` ← `PCSel` ? {`alu_target`[31:2],2'b00} : `pc_q`+4. Also `inst_valid` ← 0, and go to FETCH.
  - If `stall`=1: hold everything. `PCSel` and `alu_target` are ignored while stalled.
- `misalign_err` pulses for one cycle in the VALID→FETCH transition when `PCSel`=1 and `alu_target`[1:0]≠0. The target is still taken with its low bits cleared.
- `Inst` = `inst_valid` ? `inst_q` : 32'h0000_0013 (`addi x0,x0,0`). The decoder therefore never sees stale or X data.
- `PC_plus4` = `pc_q`+4 combinationally.
- Arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 = 32'h0000_0000, with no flag.
- `imem_rvalid` outside WAIT is ignored. This covers late responses to a request issued before a reset.
- At most one request is outstanding.

## Timing
- Reset values (asynchronous):
  - `pc_q`=`RESET_PC`, `inst_q`=32'h0000_0013, `inst_valid`=0
  - `imem_req`=0, `misalign_err`=0, state=IDLE
- First `imem_req` is asserted in the second rising-edge cycle after `reset_n` rises.
- Minimum throughput is one instruction per 3 cycles (FETCH, WAIT, VALID), with `imem_ready` high in FETCH and `imem_rvalid` on the first WAIT cycle.
- `imem_rvalid` arriving in the same cycle as acceptance is not supported. Memory returns data at least one cycle after `imem_ready`.
- Reset asserted in any state aborts immediately and returns to reset values. There is no pending-request bookkeeping across reset.
- `Inst`, `PC` and `inst_valid` are register outputs (plus a NOP mux). `imem_req` and `imem_addr` are decoded from state and `pc_q`, with no combinational path from `imem_*` inputs.

## Structure
- `risc_v_defines.vh` receives:
  - `NOP_INST` (32'h0000_0013)
  - the fetch FSM state encodings (`FETCH_IDLE`, `FETCH_REQ`, `FETCH_WAIT`, `FETCH_VALID`, 2 bits)
  - the default `RESET_PC`
- One sub-module, `pc_next`: combinational adder and mux producing next-PC, `PC_plus4` and `misalign_err_d` from `pc_q`, `PCSel` and `alu_target`.
- The FSM and registers live in `inst_fetch`.

## Test plan
- Reset with `RESET_PC`=32'h0000_1000:
  - `Inst`=32'h0000_0013 and `inst_valid`=0 during reset.
  - First `imem_req` with `imem_addr`=32'h0000_1000 two cycles after release.
- Sequential fetch: memory is zero-wait and returns 32'h0000_0033, 32'h0040_0093, … with `PCSel`=0 and `stall`=0.
  - `PC` goes 0x1000, 0x1004, 0x1008, with `inst_valid` high every 3rd cycle.
- Taken branch: in VALID with `PCSel`=1 and `alu_target`=32'h0000_2000, the next `imem_addr` is 32'h0000_2000 and `misalign_err`=0.
- Misaligned target: `alu_target`=32'h0000_2002 gives fetch address 32'h0000_2000 and a single-cycle `misalign_err` pulse.
- Stall and slow memory:
  - `stall`=1 for 5 cycles in VALID holds `Inst`/`PC` and keeps `imem_req`=0.
  - `imem_ready` low for 4 cycles holds `imem_addr` constant.
  - A spurious `imem_rvalid` in FETCH is ignored.
- Edge cases:
  - Reset mid-WAIT, then `imem_rvalid` during IDLE: no capture.
  - PC at 32'hFFFF_FFFC with `PCSel`=0 wraps to 32'h0000_0000.
